// File: rtl/ram_write_arbiter_if.sv
// rtl/ram_write_arbiter_if.sv - producer handshake and RAM write-port bundle for ram_write_arbiter
interface ram_write_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              i_req0_valid;
  logic              o_req0_ready;
  logic [63:0]       i_req0_data;
  logic [7:0]        i_req0_byteen;
  logic              i_req1_valid;
  logic              o_req1_ready;
  logic [63:0]       i_req1_data;
  logic [7:0]        i_req1_byteen;
  logic [63:0]       o_data;
  logic [ADDR_W-1:0] o_address;
  logic [7:0]        o_byteen;
  logic              o_wbit;

  // Arbiter side: consumes producer requests, drives the RAM port.
  modport slave (
    input  i_req0_valid, i_req0_data, i_req0_byteen,
    input  i_req1_valid, i_req1_data, i_req1_byteen,
    output o_req0_ready, o_req1_ready,
    output o_data, o_address, o_byteen, o_wbit
  );

  // Producer/RAM side: drives requests, observes grants and the write port.
  modport master (
    output i_req0_valid, i_req0_data, i_req0_byteen,
    output i_req1_valid, i_req1_data, i_req1_byteen,
    input  o_req0_ready, o_req1_ready,
    input  o_data, o_address, o_byteen, o_wbit
  );
endinterface

// File: rtl/ram_write_arbiter.sv
// rtl/ram_write_arbiter.sv - round-robin two-channel arbiter owning the sample-RAM ring-buffer write port
module ram_write_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int BASE_ADDR    = 0,
  parameter int LAST_ADDR    = 16383,
  parameter int GAP_CYCLES   = 1,
  parameter int STOP_ON_WRAP = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  ram_write_arbiter_if.slave   bus,
  output logic                 o_last_grant,
  output logic                 o_wrapped,
  output logic                 o_halted,
  output logic [31:0]          o_word_count
);

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(LAST_ADDR);
  // Final count value in GAP; unused when GAP_CYCLES is 0 since GAP is never entered.
  localparam logic [7:0]        GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        gap_cnt;
  logic [63:0]       data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        be_q;
  logic              wbit_q;
  logic              grant0;
  logic              grant1;
  logic              accept;

  assign accept           = grant0 | grant1;
  assign bus.o_req0_ready = grant0;
  assign bus.o_req1_ready = grant1;
  assign bus.o_data       = data_q;
  assign bus.o_address    = addr_q;
  assign bus.o_byteen     = be_q;
  assign bus.o_wbit       = wbit_q;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and grant decode; grants only open in IDLE and never while reset is asserted.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (i_en && !o_halted && !i_rst) begin
          if (bus.i_req0_valid && bus.i_req1_valid) begin
            if (o_last_grant) grant0 = 1'b1;
            else              grant1 = 1'b1;
          end else if (bus.i_req0_valid) begin
            grant0 = 1'b1;
          end else if (bus.i_req1_valid) begin
            grant1 = 1'b1;
          end
        end
        if (grant0 || grant1) state_next = WRITE;
      end
      WRITE:   state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output registers, ring pointer, gap counter and status; the accepted word is latched on the accept edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr          <= BASE;
      gap_cnt      <= 8'd0;
      data_q       <= 64'd0;
      addr_q       <= BASE;
      be_q         <= 8'd0;
      wbit_q       <= 1'b0;
      o_last_grant <= 1'b1;
      o_wrapped    <= 1'b0;
      o_halted     <= 1'b0;
      o_word_count <= 32'd0;
    end else begin
      wbit_q <= accept;
      if (accept) begin
        data_q       <= grant1 ? bus.i_req1_data : bus.i_req0_data;
        be_q         <= grant1 ? bus.i_req1_byteen : bus.i_req0_byteen;
        addr_q       <= ptr;
        o_last_grant <= grant1;
      end
      if (state == WRITE) begin
        ptr <= (ptr == LAST) ? BASE : ptr + ADDR_W'(1);
        if (o_word_count != 32'hFFFF_FFFF) o_word_count <= o_word_count + 32'd1;
        if (addr_q == LAST) begin
          o_wrapped <= 1'b1;
          if (STOP_ON_WRAP != 0) o_halted <= 1'b1;
        end
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
    end
  end

endmodule
